// File: rtl/wt_mem_responder.sv
// Memory-side responder behind the write-through data cache.
// Loads and stores are serviced from a small word memory at acceptance time.
// Each result is queued and answered in acceptance order after a fixed latency.
module wt_mem_responder #(
  parameter int DataWidth      = 64,
  parameter int AddrWidth      = 64,
  parameter int TidWidth       = 2,
  parameter int MaxOutstanding = 7,
  parameter int Latency        = 3,
  parameter int MemWords       = 64
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  logic                                  req_we_i,
  input  logic [TidWidth-1:0]                   req_tid_i,
  input  logic [AddrWidth-1:0]                  req_addr_i,
  input  logic [DataWidth-1:0]                  req_wdata_i,
  input  logic [DataWidth/8-1:0]                req_be_i,
  output logic                                  rsp_valid_o,
  input  logic                                  rsp_ready_i,
  output logic [TidWidth-1:0]                   rsp_tid_o,
  output logic                                  rsp_is_store_o,
  output logic [DataWidth-1:0]                  rsp_rdata_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o
);

  localparam int BeWidth = DataWidth / 8;
  localparam int ByteOff = $clog2(BeWidth);
  localparam int IdxW    = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam int PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int OccW    = $clog2(MaxOutstanding + 1);
  localparam int CntW    = (Latency > 1) ? $clog2(Latency) : 1;

  localparam logic [CntW-1:0] CntInit = CntW'(Latency - 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);
  localparam logic [OccW-1:0] OccMax  = OccW'(MaxOutstanding);

  // Word memory and pending queue storage
  logic [DataWidth-1:0] mem_reg  [MemWords];
  logic [TidWidth-1:0]  q_tid_reg  [MaxOutstanding];
  logic                 q_st_reg   [MaxOutstanding];
  logic [DataWidth-1:0] q_data_reg [MaxOutstanding];
  logic [CntW-1:0]      q_cnt_reg  [MaxOutstanding];

  logic [PtrW-1:0] head_reg, head_next;
  logic [PtrW-1:0] tail_reg, tail_next;
  logic [OccW-1:0] occ_reg, occ_next;

  logic                      accept;
  logic                      pop;
  logic                      head_due;
  logic [IdxW-1:0]           word_idx;
  logic [DataWidth-1:0]      acc_data;
  logic [MaxOutstanding-1:0] wr_sel;
  logic                      unused_addr;

  // Only the word-index bits of the address matter; the rest alias.
  assign unused_addr = ^req_addr_i;
  assign word_idx    = req_addr_i[ByteOff +: IdxW];

  // Slot availability comes from registered occupancy only.
  assign req_ready_o = !rst_i && (occ_reg < OccMax);
  assign accept      = req_valid_i && req_ready_o;

  assign head_due    = (q_cnt_reg[head_reg] == '0);
  assign rsp_valid_o = (occ_reg != '0) && head_due;
  assign pop         = rsp_valid_o && rsp_ready_i;

  // Outputs are held at zero whenever nothing is being presented.
  assign rsp_tid_o      = rsp_valid_o ? q_tid_reg[head_reg]  : '0;
  assign rsp_is_store_o = rsp_valid_o ? q_st_reg[head_reg]   : 1'b0;
  assign rsp_rdata_o    = rsp_valid_o ? q_data_reg[head_reg] : '0;
  assign outstanding_o  = occ_reg;

  // Loads capture the word as it stands now; stores acknowledge with zero data.
  assign acc_data = req_we_i ? '0 : mem_reg[word_idx];

  // One-hot write select for the entry at the tail
  genvar gi;
  generate
    for (gi = 0; gi < MaxOutstanding; gi++) begin : g_wr_sel
      assign wr_sel[gi] = accept && (tail_reg == PtrW'(gi));
    end
  endgenerate

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  // Pointer and occupancy next-state
  always_comb begin
    head_next = head_reg;
    tail_next = tail_reg;
    occ_next  = occ_reg;
    if (accept) tail_next = ptr_inc(tail_reg);
    if (pop)    head_next = ptr_inc(head_reg);
    case ({accept, pop})
      2'b10:   occ_next = occ_reg + OccW'(1);
      2'b01:   occ_next = occ_reg - OccW'(1);
      default: occ_next = occ_reg;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_reg <= '0;
      tail_reg <= '0;
      occ_reg  <= '0;
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
      occ_reg  <= occ_next;
    end
  end

  // Byte-enabled store into the word memory; cleared by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < MemWords; w++) mem_reg[w] <= '0;
    end else if (accept && req_we_i) begin
      for (int b = 0; b < BeWidth; b++) begin
        if (req_be_i[b]) mem_reg[word_idx][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
      end
    end
  end

  // Queue entries: load on accept, otherwise count latency down to zero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int e = 0; e < MaxOutstanding; e++) begin
        q_tid_reg[e]  <= '0;
        q_st_reg[e]   <= 1'b0;
        q_data_reg[e] <= '0;
        q_cnt_reg[e]  <= '0;
      end
    end else begin
      for (int e = 0; e < MaxOutstanding; e++) begin
        if (wr_sel[e]) begin
          q_tid_reg[e]  <= req_tid_i;
          q_st_reg[e]   <= req_we_i;
          q_data_reg[e] <= acc_data;
          q_cnt_reg[e]  <= CntInit;
        end else if (q_cnt_reg[e] != '0) begin
          q_cnt_reg[e]  <= q_cnt_reg[e] - CntW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_wt_mem_responder.sv
// Directed bench for wt_mem_responder with hand-computed expectations.
module tb_wt_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_tid_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic [7:0]  req_be_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [1:0]  rsp_tid_o;
  logic        rsp_is_store_o;
  logic [63:0] rsp_rdata_o;
  logic [2:0]  outstanding_o;

  int tests = 0;
  int fails = 0;

  wt_mem_responder dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_we_i      (req_we_i),
    .req_tid_i     (req_tid_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .req_be_i      (req_be_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_tid_o     (rsp_tid_o),
    .rsp_is_store_o(rsp_is_store_o),
    .rsp_rdata_o   (rsp_rdata_o),
    .outstanding_o (outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] tid, input logic st,
                         input logic [63:0] rd);
    $display("[TB] %s: rsp valid=%0b tid=%0d store=%0b rdata=%0h",
             tag, rsp_valid_o, rsp_tid_o, rsp_is_store_o, rsp_rdata_o);
    chk({tag, ".valid"}, 64'(rsp_valid_o), 64'(1));
    chk({tag, ".tid"},   64'(rsp_tid_o), 64'(tid));
    chk({tag, ".store"}, 64'(rsp_is_store_o), 64'(st));
    chk({tag, ".rdata"}, rsp_rdata_o, rd);
  endtask

  task automatic set_req(input logic we, input logic [1:0] tid, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] be);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_tid_i   = tid;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_be_i    = be;
  endtask

  // Store in cycle A, load in cycle A+1; responses in A+3 and A+4.
  task automatic store_load(input string tag, input logic [1:0] st_tid, input logic [63:0] st_addr,
                            input logic [63:0] wdata, input logic [7:0] be,
                            input logic [1:0] ld_tid, input logic [63:0] ld_addr,
                            input logic [63:0] exp);
    set_req(1'b1, st_tid, st_addr, wdata, be);
    tick();
    set_req(1'b0, ld_tid, ld_addr, 64'h0, 8'h00);
    tick();
    req_valid_i = 1'b0;
    chk({tag, ".occ2"}, 64'(outstanding_o), 64'(2));
    chk({tag, ".early"}, 64'(rsp_valid_o), 64'(0));
    tick();
    chk_rsp({tag, ".st"}, st_tid, 1'b1, 64'h0);
    tick();
    chk_rsp({tag, ".ld"}, ld_tid, 1'b0, exp);
    tick();
    chk({tag, ".empty"}, 64'(rsp_valid_o), 64'(0));
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_tid_i = 2'd0;
    req_addr_i = 64'h0; req_wdata_i = 64'h0; req_be_i = 8'h0; rsp_ready_i = 1'b0;
    tick();
    tick();
    chk("rst.ready", 64'(req_ready_o), 64'(0));
    chk("rst.valid", 64'(rsp_valid_o), 64'(0));
    chk("rst.occ",   64'(outstanding_o), 64'(0));
    chk("rst.tid",   64'(rsp_tid_o), 64'(0));
    chk("rst.store", 64'(rsp_is_store_o), 64'(0));
    chk("rst.rdata", rsp_rdata_o, 64'h0);

    // Single store: valid exactly three cycles after acceptance
    rst_i = 1'b0;
    rsp_ready_i = 1'b1;
    set_req(1'b1, 2'd1, 64'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    #1 chk("st1.ready", 64'(req_ready_o), 64'(1));
    tick();
    req_valid_i = 1'b0;
    chk("st1.occ", 64'(outstanding_o), 64'(1));
    chk("st1.t1", 64'(rsp_valid_o), 64'(0));
    tick();
    chk("st1.t2", 64'(rsp_valid_o), 64'(0));
    tick();
    chk_rsp("st1.t3", 2'd1, 1'b1, 64'h0);
    tick();
    chk("st1.t4", 64'(rsp_valid_o), 64'(0));
    chk("st1.occ0", 64'(outstanding_o), 64'(0));

    // Back-to-back store/load, partial store, aliasing
    store_load("full", 2'd2, 64'h10, 64'h01234567_89ABCDEF, 8'hFF, 2'd3, 64'h10,
               64'h01234567_89ABCDEF);
    store_load("part", 2'd0, 64'h10, 64'hFFFFFFFF_AAAA5555, 8'h0F, 2'd1, 64'h10,
               64'h01234567_AAAA5555);
    store_load("alias", 2'd2, 64'h0, 64'hA5A5A5A5_5A5A5A5A, 8'hFF, 2'd3, 64'h200,
               64'hA5A5A5A5_5A5A5A5A);

    // Fill the queue under backpressure
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_req(1'b0, 2'(i), 64'h10, 64'h0, 8'h00);
      chk($sformatf("fill%0d.ready", i), 64'(req_ready_o), 64'(1));
      tick();
    end
    set_req(1'b0, 2'd3, 64'h10, 64'h0, 8'h00);
    chk("full.occ", 64'(outstanding_o), 64'(7));
    chk("full.ready", 64'(req_ready_o), 64'(0));
    tick();
    chk("full.occ_hold", 64'(outstanding_o), 64'(7));
    chk("full.ready_hold", 64'(req_ready_o), 64'(0));
    chk_rsp("full.head", 2'd0, 1'b0, 64'h01234567_AAAA5555);
    // One-cycle ready pulse: pop happens, 8th request not taken this cycle
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    chk("pulse.occ", 64'(outstanding_o), 64'(6));
    chk("pulse.ready", 64'(req_ready_o), 64'(1));
    chk_rsp("pulse.head", 2'd1, 1'b0, 64'h01234567_AAAA5555);
    tick();
    req_valid_i = 1'b0;
    chk("pulse.accept", 64'(outstanding_o), 64'(7));
    rsp_ready_i = 1'b1;
    for (int j = 1; j < 7; j++) begin
      chk_rsp($sformatf("drain%0d", j), 2'(j), 1'b0, 64'h01234567_AAAA5555);
      tick();
    end
    chk_rsp("drain7", 2'd3, 1'b0, 64'h01234567_AAAA5555);
    tick();
    chk("drain.empty", 64'(rsp_valid_o), 64'(0));
    chk("drain.occ", 64'(outstanding_o), 64'(0));

    // Reset with three entries pending
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b0, 2'(i), 64'h10, 64'h0, 8'h00);
      tick();
    end
    req_valid_i = 1'b0;
    chk("mid.occ3", 64'(outstanding_o), 64'(3));
    rst_i = 1'b1;
    tick();
    chk("mid.occ0", 64'(outstanding_o), 64'(0));
    chk("mid.valid", 64'(rsp_valid_o), 64'(0));
    chk("mid.ready", 64'(req_ready_o), 64'(0));
    rst_i = 1'b0;
    rsp_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("mid.quiet%0d", k), 64'(rsp_valid_o), 64'(0));
    end
    set_req(1'b0, 2'd1, 64'h10, 64'h0, 8'h00);
    tick();
    req_valid_i = 1'b0;
    tick();
    tick();
    chk_rsp("mid.load", 2'd1, 1'b0, 64'h0);
    tick();
    chk("mid.empty", 64'(rsp_valid_o), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
